// File: rtl/eight_bit_counter_pkg.sv
// Shared definitions for the loadable up/down counter: width, direction
// encodings and the per-edge operation decode used by the top-level mux.
package eight_bit_counter_pkg;

  localparam int CNT_WIDTH = 8;

  // Direction encodings for incOrDec.
  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  // Non-clear operations; clear is handled as the synchronous reset.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2
  } cnt_op_e;

  // Load beats stepping, so a loaded value is never stepped in the same cycle.
  function automatic cnt_op_e decode_op(input logic load, input logic enable);
    cnt_op_e op;
    if (load) begin
      op = OP_LOAD;
    end else if (enable) begin
      op = OP_STEP;
    end else begin
      op = OP_HOLD;
    end
    return op;
  endfunction

endpackage : eight_bit_counter_pkg

// File: rtl/eight_bit_counter_step.sv
// Combinational +/-1 step of the count with silent modulo-2^WIDTH wrap.
module counter_step
  import eight_bit_counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] next_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Select increment or decrement; carry/borrow out is deliberately dropped.
  always_comb begin
    next_o = count_i;
    if (dir_i == DIR_DEC) begin
      next_o = count_i - ONE;
    end else begin
      next_o = count_i + ONE;
    end
  end

endmodule : counter_step

// File: rtl/eight_bit_counter.sv
// Loadable up/down counter with synchronous clear, parallel load and count
// enable. The output is taken straight from the count register.
module eight_bit_counter
  import eight_bit_counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic [WIDTH-1:0] myInput,
  input  logic             clear,
  input  logic             load,
  input  logic             clock,
  input  logic             incOrDec,
  input  logic             countEnabler,
  output logic [WIDTH-1:0] myOutput
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] step_s;
  cnt_op_e          op_s;

  counter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .count_i (count_q),
    .dir_i   (incOrDec),
    .next_o  (step_s)
  );

  // Priority mux for the non-clear cases: load, then step, then hold.
  always_comb begin
    op_s    = decode_op(load, countEnabler);
    count_d = count_q;
    case (op_s)
      OP_LOAD: count_d = myInput;
      OP_STEP: count_d = step_s;
      OP_HOLD: count_d = count_q;
      default: count_d = count_q;
    endcase
  end

  // Count register; clear wins over every other control on the same edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign myOutput = count_q;

endmodule : eight_bit_counter

// File: tb/tb_eight_bit_counter.sv
// Self-checking bench for eight_bit_counter: expected values are queued when
// stimulus is applied and popped for comparison after the sampling edge.
module tb_eight_bit_counter;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic       incOrDec = 1'b0;
  logic       countEnabler = 1'b0;
  logic [7:0] myInput = 8'h00;
  logic [7:0] myOutput;

  logic [7:0] exp_q[$];
  int         checks = 0;
  int         passed = 0;

  eight_bit_counter #(.WIDTH(8)) dut (
    .myInput      (myInput),
    .clear        (clear),
    .load         (load),
    .clock        (clock),
    .incOrDec     (incOrDec),
    .countEnabler (countEnabler),
    .myOutput     (myOutput)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks required completion", checks);
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, let the edge sample them, then settle 1 time unit.
  task automatic drive(input logic c, input logic l, input logic [7:0] d,
                       input logic dir, input logic en);
    clear = c; load = l; myInput = d; incOrDec = dir; countEnabler = en;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    exp_q.push_back(8'h00);
    drive(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (myOutput !== e) $display("FAIL reset_single: got %h required %h", myOutput, e);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h00);
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (myOutput !== e) $display("FAIL reset_hold[%0d]: got %h required %h", i, myOutput, e);
      else passed++;
    end
  endtask

  task automatic test_load_count_up();
    logic [7:0] e;
    exp_q.push_back(8'h0B);
    drive(1'b0, 1'b1, 8'h0B, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (myOutput !== e) $display("FAIL load_0b: got %h required %h", myOutput, e);
    else passed++;
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(8'h0C + 8'(i));
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (myOutput !== e) $display("FAIL count_up[%0d]: got %h required %h", i, myOutput, e);
      else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h1A);
      drive(1'b0, 1'b0, 8'h77, 1'(i % 2), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (myOutput !== e) $display("FAIL hold_1a[%0d]: got %h required %h", i, myOutput, e);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    logic [7:0] up_exp[3];
    logic [7:0] dn_exp[3];
    up_exp = '{8'hFF, 8'h00, 8'h01};
    dn_exp = '{8'h00, 8'hFF, 8'hFE};
    drive(1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(up_exp[i]);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (myOutput !== e) $display("FAIL wrap_up[%0d]: got %h required %h", i, myOutput, e);
      else passed++;
    end
    drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(dn_exp[i]);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (myOutput !== e) $display("FAIL wrap_down[%0d]: got %h required %h", i, myOutput, e);
      else passed++;
    end
  endtask

  task automatic test_priority();
    logic [7:0] e;
    drive(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    exp_q.push_back(8'h00);
    drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (myOutput !== e) $display("FAIL prio_clear: got %h required %h", myOutput, e);
    else passed++;
    exp_q.push_back(8'h55);
    drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (myOutput !== e) $display("FAIL prio_load_up: got %h required %h", myOutput, e);
    else passed++;
    exp_q.push_back(8'hA0);
    drive(1'b0, 1'b1, 8'hA0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (myOutput !== e) $display("FAIL prio_load_down: got %h required %h", myOutput, e);
    else passed++;
  endtask

  task automatic test_direction_flip();
    logic [7:0] e;
    drive(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    exp_q.push_back(8'h12);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (myOutput !== e) $display("FAIL dir_up2: got %h required %h", myOutput, e);
    else passed++;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    exp_q.push_back(8'h0D);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (myOutput !== e) $display("FAIL dir_down5: got %h required %h", myOutput, e);
    else passed++;
  endtask

  task automatic test_mid_clear();
    logic [7:0] e;
    drive(1'b0, 1'b1, 8'h0B, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    exp_q.push_back(8'h0F);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (myOutput !== e) $display("FAIL mid_pre: got %h required %h", myOutput, e);
    else passed++;
    exp_q.push_back(8'h00);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (myOutput !== e) $display("FAIL mid_clear: got %h required %h", myOutput, e);
    else passed++;
    exp_q.push_back(8'h01);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (myOutput !== e) $display("FAIL mid_resume: got %h required %h", myOutput, e);
    else passed++;
  endtask

  // Random back-to-back controls against a small reference model.
  task automatic test_back_to_back();
    logic [7:0] model;
    logic [7:0] e;
    logic       c, l, dir, en;
    logic [7:0] d;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    model = 8'h00;
    for (int i = 0; i < 300; i++) begin
      c   = ($urandom_range(0, 15) == 0);
      l   = ($urandom_range(0, 7) == 0);
      dir = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom_range(0, 255));
      if (c)       model = 8'h00;
      else if (l)  model = d;
      else if (en) model = dir ? model - 8'h01 : model + 8'h01;
      exp_q.push_back(model);
      drive(c, l, d, dir, en);
      e = exp_q.pop_front();
      checks++;
      if (myOutput !== e) $display("FAIL random[%0d]: got %h required %h", i, myOutput, e);
      else passed++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_load_count_up();
    test_wrap();
    test_priority();
    test_direction_flip();
    test_mid_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_eight_bit_counter
